reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8: data width of the shared register.
REQ-002 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester write request, bit i = requester i.
- wdata  input  4*N  packed write data; requester i owns bits [i*N +: N].
- grant  output  4  one-hot grant, registered.
- ack  output  4  one-cycle pulse, bit i = requester i write committed.
- reg_data_in  output  N  drives data_in of the shared n_bit_register.
- reg_write_enable  output  1  drives write_enable of the shared n_bit_register.
- busy  output  1  high whenever state is not IDLE.
- write_count  output  8  number of committed writes, wraps 255->0.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WRITE, ACK.
REQ-004 IDLE: if req is nonzero at a rising edge, the FSM SHALL select winner i round-robin and go to WRITE; otherwise it stays in IDLE.
REQ-005 Round-robin SHALL use a 2-bit pointer ptr and search ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit wins.
REQ-006 On the IDLE->WRITE edge, the block SHALL register grant to one-hot(i) and capture wdata[i*N +: N] into reg_data_in.
REQ-007 WRITE SHALL last exactly one cycle with reg_write_enable=1, then go to ACK; the shared register captures reg_data_in on that edge.
REQ-008 ACK SHALL last exactly one cycle with reg_write_enable=0, ack=one-hot(i), grant unchanged; then go to IDLE.
REQ-009 On the ACK->IDLE edge, the block SHALL clear grant to 0, set ptr to i+1 mod 4, and increment write_count by 1 (mod 256).
REQ-010 Latency SHALL be fixed: req sampled at edge E0 -> write_enable high E0..E1 -> ack high E1..E2 -> IDLE after E2. Peak throughput is one write per 3 cycles.
REQ-011 req and wdata SHALL be ignored in WRITE and ACK; a req drop after E0 SHALL NOT abort the write, and wdata changes after E0 SHALL NOT alter reg_data_in.
REQ-012 A requester whose req is still high in IDLE after its ack SHALL be treated as a new request, subject to round-robin.
REQ-013 reg_data_in SHALL hold its last captured value outside WRITE; reg_write_enable is the only qualifier.
REQ-014 grant SHALL have at most one bit set; ack SHALL have at most one bit set; ack SHALL be nonzero only in ACK.
REQ-015 busy SHALL equal (state != IDLE), decoded from state only.

Reset
REQ-016 rst_n low SHALL immediately force, in any state:
- state=IDLE
- grant=0, ack=0
- reg_write_enable=0, reg_data_in=0
- ptr=0, write_count=0, busy=0
REQ-017 Reset asserted mid-WRITE or mid-ACK SHALL abort the transaction: no ack issued, write_count not incremented.
REQ-018 After rst_n deasserts, the first rising edge SHALL perform normal IDLE arbitration with ptr=0.

Verification
REQ-019 A bench SHALL cover at least these directed scenarios:
- Single request: req=4'b0100, wdata[23:16]=8'hA5 -> next cycle grant=4'b0100, reg_write_enable=1, reg_data_in=8'hA5; following cycle ack=4'b0100; register data_out=8'hA5; write_count=1.
- All request from reset: req=4'b1111 held, distinct data -> grants in order 0,1,2,3,0, each 3 cycles apart; write_count=5 after five acks.
- Fairness: req0 held high, req2 pulsed once -> after grant 0, ptr=1, so req2 wins next arbitration before req0 repeats.
- Data stability: wdata of the winner changed and req dropped during WRITE -> reg_data_in keeps the value captured at grant; ack still issued.
- Reset mid-WRITE: rst_n pulled low while reg_write_enable=1 -> outputs clear immediately, no ack, write_count unchanged; after release with req=4'b1000, grant=4'b1000.
- Wrap: 256 committed writes -> write_count returns to 0.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if
//   Bundles the requester side (req/wdata), the grant/ack handshake and the
//   drive of the shared n_bit_register into one bus.
//   master : requester/environment side (drives req, wdata)
//   slave  : arbiter side (drives grant, ack, reg_*, busy, write_count)
// Signals
//   req              [3:0]     per-requester write request
//   wdata            [4*N-1:0] packed write data, requester i owns [i*N +: N]
//   grant            [3:0]     one-hot registered grant
//   ack              [3:0]     one-cycle commit pulse
//   reg_data_in      [N-1:0]   data_in of the shared register
//   reg_write_enable           write_enable of the shared register
//   busy                       arbiter not idle
//   write_count      [7:0]     committed writes, wraps 255->0
interface reg_write_arbiter_if #(
  parameter int N = 8
);
  logic [3:0]     req;
  logic [4*N-1:0] wdata;
  logic [3:0]     grant;
  logic [3:0]     ack;
  logic [N-1:0]   reg_data_in;
  logic           reg_write_enable;
  logic           busy;
  logic [7:0]     write_count;

  modport master (
    output req, wdata,
    input  grant, ack, reg_data_in, reg_write_enable, busy, write_count
  );

  modport slave (
    input  req, wdata,
    output grant, ack, reg_data_in, reg_write_enable, busy, write_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Four-requester round-robin arbiter serialising writes into one shared
//   N-bit register. Each transaction is IDLE -> WRITE -> ACK -> IDLE with a
//   fixed one-cycle WRITE (write_enable high) and one-cycle ACK (ack pulse).
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : reg_write_arbiter_if.slave (req/wdata in; grant/ack/reg_*/busy/
//            write_count out)
module reg_write_arbiter #(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst_n,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     win_q, win_d;
  logic [3:0]     grant_q, grant_d;
  logic [N-1:0]   data_q, data_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [3:0][N-1:0] wd;
  logic [1:0]        pick;
  logic [1:0]        idx;
  logic              found;

  assign wd = bus.wdata;

  // Round-robin search ptr, ptr+1, ptr+2, ptr+3 (2-bit add wraps mod 4).
  // Walking from the farthest slot back toward ptr leaves the nearest
  // requester as the final assignment.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = WRITE;
          win_d   = pick;
          grant_d = 4'b0001 << pick;
          data_d  = wd[pick];
        end
      end
      WRITE: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = win_q + 2'd1;
        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // ack/write_enable/busy decode from state so reset clears them at once.
  assign bus.grant            = grant_q;
  assign bus.ack              = (state_q == ACK) ? grant_q : 4'b0000;
  assign bus.reg_write_enable = (state_q == WRITE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.reg_data_in      = data_q;
  assign bus.write_count      = cnt_q;

endmodule
